mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have ports: if_req  in  1  fetch request (level); if_addr  in  32  fetch byte address; if_cancel  in  1  branch flush, abort fetch.
REQ-003 SHALL have ports: mem_req  in  1  load/store request (level); mem_we  in  1  1=store; mem_addr  in  32; mem_size  in  2  00 byte, 01 half, 10/11 word; mem_wdata  in  32  store data, byte 0 = bits 7:0.
REQ-004 SHALL have ports: if_done  out  1; if_data  out  32; mem_done  out  1; mem_rdata  out  32.
REQ-005 SHALL have ports: ram_a  out  32  RAM byte address; ram_wr  out  1  1=write; ram_dout  out  8  write byte; ram_din  in  8  read byte, valid one cycle after its address.

Function
REQ-006 SHALL implement states IDLE, READ, WRITE, DONE, with a byte counter cnt (0..4) and an owner flag (IF/MEM).
REQ-007 In IDLE, SHALL sample requests at the clock edge: mem_req wins over if_req; the winner's address, size, we and wdata SHALL be latched; next state is READ (fetch, or load) or WRITE (store), with cnt=0.
REQ-008 Fetch length SHALL be 4 bytes; MEM length N SHALL be 1/2/4 per mem_size.
REQ-009 In READ, SHALL drive ram_a=base+cnt, ram_wr=0; when cnt>=1, SHALL capture ram_din into result byte cnt-1; when cnt==N, SHALL go to DONE; otherwise cnt increments.
REQ-010 In WRITE, SHALL drive ram_a=base+cnt, ram_wr=1, ram_dout=wdata byte cnt; at cnt==N-1, SHALL go to DONE.
REQ-011 Latency, counted from the request-sampled cycle = 0: read done in cycle N+2 (fetch: cycle 6); write done in cycle N+1.
REQ-012 In DONE, SHALL pulse the owner's done for exactly one cycle with its data valid; next state is IDLE; no request is accepted in DONE.
REQ-013 Requesters SHALL deassert req at the edge ending their done cycle; the arbiter relies on this so that no duplicate is issued.
REQ-014 mem_rdata SHALL zero-extend: bytes at or beyond N are 0 (sign handling is downstream).
REQ-015 if_data and mem_rdata SHALL hold their last value outside done cycles; done signals SHALL be 0 outside DONE.
REQ-016 ram_wr SHALL be 0 in IDLE, READ and DONE; ram_a and ram_dout SHALL be 0 in IDLE.
REQ-017 if_cancel=1 while the owner is IF, in READ, SHALL abort the fetch: next state IDLE, no if_done.
REQ-018 if_cancel=1 in DONE with owner IF SHALL suppress if_done.
REQ-019 if_cancel=1 in IDLE SHALL block IF acceptance that cycle; mem_req is still accepted.
REQ-020 if_cancel SHALL have no effect on MEM transactions.
REQ-021 An unused request SHALL wait; there is no preemption of an in-flight transaction by either requester.
REQ-022 A back-to-back MEM request SHALL still take precedence after an IF DONE; IF starvation is acceptable, because MEM requests are bounded by the pipeline.

Reset
REQ-023 On rst=1 at a clock edge, including mid-transaction, SHALL enter IDLE with cnt=0, owner=IF, and latched regs 0.
REQ-024 On reset, SHALL set if_done=0, mem_done=0, if_data=0, mem_rdata=0, ram_wr=0, ram_a=0, ram_dout=0; an interrupted write is not completed.

Structure
REQ-025 State encodings and mem_size codes SHALL be defined as constants in defines.v, shared with mem/mem_wb.
REQ-026 SHALL be a single module with no sub-module; byte assembly is done in-line by cnt.

Verification
REQ-027 Test 1: if_req, if_addr=0x100, RAM[0x100..0x103]=11,22,33,44 -> ram_a 0x100..0x103 in cycles 1-4; if_done in cycle 6, if_data=0x44332211.
REQ-028 Test 2: mem_req and if_req both asserted in the same cycle, with a load byte at 0x20 where RAM=0x8F -> MEM served first, mem_done in cycle 3 with mem_rdata=0x0000008F; the IF fetch then starts in the following IDLE.
REQ-029 Test 3: store half, mem_addr=0x40, wdata=0xAABBCCDD -> ram_wr=1 with (0x40,DD) then (0x41,CC); mem_done in cycle 3; ram_wr=0 afterwards.
REQ-030 Test 4: fetch started, if_cancel pulsed in cycle 3 -> no if_done; IDLE in cycle 4; a new if_req is then accepted normally.
REQ-031 Test 5: store word, rst asserted in cycle 2 -> ram_wr=0 and all outputs 0 from cycle 3; mem_done is never asserted.
REQ-032 Test 6: requester holds req through done and drops it at the following edge -> exactly one transaction is issued (check ram_a activity count).

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store arbiter in front of
// the byte-wide RAM port.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  localparam logic [CNT_W-1:0] FETCH_LEN = CNT_W'(4);

  // Transaction latched at acceptance; len is the byte count (1, 2 or 4).
  typedef struct packed {
    owner_e              owner;
    logic                we;
    logic [CNT_W-1:0]    len;
    logic [ADDR_W-1:0]   base;
    logic [DATA_W-1:0]   wdata;
  } xfer_t;

  function automatic logic [CNT_W-1:0] size_len(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return CNT_W'(1);
      SIZE_HALF: return CNT_W'(2);
      default:   return CNT_W'(4);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] len_mask(input logic [CNT_W-1:0] len);
    case (len)
      CNT_W'(1): return 32'h0000_00FF;
      CNT_W'(2): return 32'h0000_FFFF;
      default:   return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Little-endian byte lane select: lane 0 is bits 7:0.
  function automatic logic [BYTE_W-1:0] get_byte(input logic [DATA_W-1:0] word,
                                                 input logic [IDX_W-1:0]  idx);
    case (idx)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] word,
                                                 input logic [IDX_W-1:0]  idx,
                                                 input logic [BYTE_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = word;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM between instruction fetch and load/store,
// serialising each access into single-byte RAM cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [BYTE_W-1:0] ram_dout,
  input  logic [BYTE_W-1:0] ram_din
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  xfer_t             xfer_q, xfer_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;

  logic if_abort_c;
  logic last_rd_c;
  logic last_wr_c;
  logic rd_done_c;

  // A flush only matters while the fetch side owns the port.
  assign if_abort_c = (xfer_q.owner == OWN_IF) && if_cancel;
  assign last_rd_c  = (cnt_q == xfer_q.len);
  assign last_wr_c  = (cnt_q == (xfer_q.len - CNT_W'(1)));
  assign rd_done_c  = (state_q == ST_READ) && !if_abort_c && last_rd_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      xfer_q  <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xfer_q  <= xfer_d;
      rbuf_q  <= rbuf_d;
    end
  end

  // Next-state logic; MEM has fixed priority over fetch at acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xfer_d  = xfer_q;
    rbuf_d  = rbuf_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (mem_req) begin
          xfer_d = '{owner: OWN_MEM, we: mem_we, len: size_len(mem_size),
                     base: mem_addr, wdata: mem_wdata};
          rbuf_d  = '0;
          state_d = mem_we ? ST_WRITE : ST_READ;
        end else if (if_req && !if_cancel) begin
          xfer_d = '{owner: OWN_IF, we: 1'b0, len: FETCH_LEN,
                     base: if_addr, wdata: '0};
          rbuf_d  = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        // RAM data lags its address by one cycle, so lane cnt-1 arrives now.
        if (cnt_q != '0) begin
          rbuf_d = put_byte(rbuf_q, IDX_W'(cnt_q - CNT_W'(1)), ram_din);
        end
        if (if_abort_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (last_rd_c) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (last_wr_c) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Result registers load on the READ->DONE edge and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_data   <= '0;
      mem_rdata <= '0;
    end else if (rd_done_c) begin
      if (xfer_q.owner == OWN_IF) begin
        if_data <= rbuf_d;
      end else begin
        mem_rdata <= rbuf_d & len_mask(xfer_q.len);
      end
    end
  end

  // Output decode; a late flush in DONE still suppresses the fetch done.
  always_comb begin
    ram_a    = '0;
    ram_wr   = 1'b0;
    ram_dout = '0;
    if_done  = 1'b0;
    mem_done = 1'b0;
    case (state_q)
      ST_READ: begin
        ram_a = xfer_q.base + ADDR_W'(cnt_q);
      end
      ST_WRITE: begin
        ram_a    = xfer_q.base + ADDR_W'(cnt_q);
        ram_wr   = 1'b1;
        ram_dout = get_byte(xfer_q.wdata, IDX_W'(cnt_q));
      end
      ST_DONE: begin
        if (xfer_q.owner == OWN_IF) begin
          if_done = !if_cancel;
        end else begin
          mem_done = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule
